// File: rtl/noc_flit_buffer_if.sv
// noc_flit_buffer_if: router/demux handshake bundle for the flit buffer; error flags exist only with NOC_FLIT_BUFFER_ERR_EN
interface noc_flit_buffer_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
);
    logic [WIDTH-1:0]             i_flit_in;
    logic                         i_valid_in;
    logic [WIDTH-1:0]             o_data_out;
    logic                         o_empty_out;
    logic                         i_read_en;
    logic                         o_credit_out;
    logic [$clog2(DEPTH+1)-1:0]   o_count;
`ifdef NOC_FLIT_BUFFER_ERR_EN
    logic                         o_overflow;
    logic                         o_underflow;
`endif

    modport slave (
        input  i_flit_in, i_valid_in, i_read_en,
        output o_data_out, o_empty_out, o_credit_out, o_count
`ifdef NOC_FLIT_BUFFER_ERR_EN
        , output o_overflow, o_underflow
`endif
    );

    modport master (
        output i_flit_in, i_valid_in, i_read_en,
        input  o_data_out, o_empty_out, o_credit_out, o_count
`ifdef NOC_FLIT_BUFFER_ERR_EN
        , input o_overflow, o_underflow
`endif
    );
endinterface

// File: rtl/noc_flit_buffer.sv
// noc_flit_buffer: credit-managed show-ahead flit FIFO; sticky error flags enabled by NOC_FLIT_BUFFER_ERR_EN
module noc_flit_buffer #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input logic              clk,
    input logic              rst,
    noc_flit_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count, count_next;
    logic             empty, credit, pop, push;

    // a full buffer still accepts a flit when the head leaves in the same cycle
    always_comb begin
        pop        = bus.i_read_en & (count != '0);
        push       = bus.i_valid_in & ((count != CW'(DEPTH)) | pop);
        count_next = count + CW'(push) - CW'(pop);
    end

    // storage is cleared on reset so the head output reads zero until the first flit lands
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            credit <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= bus.i_flit_in;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count  <= count_next;
            empty  <= (count_next == '0);
            credit <= pop;
        end
    end

`ifdef NOC_FLIT_BUFFER_ERR_EN
    logic overflow, underflow;

    // sticky flags: dropped push and read of an empty buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (bus.i_valid_in & ~push) overflow <= 1'b1;
            if (bus.i_read_en & (count == '0)) underflow <= 1'b1;
        end
    end

    assign bus.o_overflow  = overflow;
    assign bus.o_underflow = underflow;
`endif

    assign bus.o_data_out   = mem[rd_ptr];
    assign bus.o_empty_out  = empty;
    assign bus.o_count      = count;
    assign bus.o_credit_out = credit;
endmodule

// File: tb/tb_noc_flit_buffer.sv
// tb_noc_flit_buffer: directed and random checks of noc_flit_buffer against a queue model
module tb_noc_flit_buffer;
    localparam int WIDTH = 4;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;

    logic [WIDTH-1:0] q[$];
    bit exp_credit = 1'b0;
    bit exp_ovf = 1'b0;
    bit exp_unf = 1'b0;

    always #5 clk = ~clk;

    noc_flit_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
    noc_flit_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_state();
        chk("count", 32'(bus.o_count), 32'(q.size()));
        chk("empty", 32'(bus.o_empty_out), 32'(q.size() == 0));
        chk("credit", 32'(bus.o_credit_out), 32'(exp_credit));
        if (q.size() != 0) chk("data", 32'(bus.o_data_out), 32'(q[0]));
`ifdef NOC_FLIT_BUFFER_ERR_EN
        chk("overflow", 32'(bus.o_overflow), 32'(exp_ovf));
        chk("underflow", 32'(bus.o_underflow), 32'(exp_unf));
`endif
    endtask

    // one clock: drive inputs, update the queue model from the buffer's rules, then check outputs
    task automatic cyc(input bit v, input logic [WIDTH-1:0] d, input bit re);
        bit pop, push;
        bus.i_valid_in = v;
        bus.i_flit_in  = d;
        bus.i_read_en  = re;
        @(posedge clk);
        pop  = re && q.size() != 0;
        push = v && (q.size() != DEPTH || pop);
        if (rst) begin
            q.delete();
            exp_credit = 1'b0;
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end else begin
            if (re && q.size() == 0) exp_unf = 1'b1;
            if (v && !push) exp_ovf = 1'b1;
            if (pop) void'(q.pop_front());
            if (push) q.push_back(d);
            exp_credit = pop;
        end
        #1;
        check_state();
    endtask

    initial begin
        bus.i_valid_in = 1'b0;
        bus.i_flit_in  = '0;
        bus.i_read_en  = 1'b0;
        rst = 1'b1;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        rst = 1'b0;
        cyc(0, 0, 0);
        chk("reset_data", 32'(bus.o_data_out), 32'h0);
        cyc(1, 4'hA, 0);
        chk("first_push_data", 32'(bus.o_data_out), 32'hA);
        cyc(1, 4'hB, 0);
        cyc(1, 4'hC, 0);
        chk("three_count", 32'(bus.o_count), 32'd3);
        cyc(0, 0, 1);
        chk("pop1_credit", 32'(bus.o_credit_out), 32'd1);
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        chk("drained_empty", 32'(bus.o_empty_out), 32'd1);
        chk("drained_credit", 32'(bus.o_credit_out), 32'd0);
        for (int i = 1; i <= 8; i++) cyc(1, WIDTH'(i), 0);
        chk("full_count", 32'(bus.o_count), 32'd8);
        cyc(1, 4'h9, 0);
        chk("drop_count", 32'(bus.o_count), 32'd8);
        chk("drop_head", 32'(bus.o_data_out), 32'h1);
        cyc(1, 4'h9, 1);
        chk("full_swap_count", 32'(bus.o_count), 32'd8);
        chk("full_swap_head", 32'(bus.o_data_out), 32'h2);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1);
        cyc(0, 0, 0);
        chk("wrap_empty", 32'(bus.o_empty_out), 32'd1);
        cyc(1, 4'h5, 1);
        chk("empty_rw_credit", 32'(bus.o_credit_out), 32'd0);
        chk("empty_rw_data", 32'(bus.o_data_out), 32'h5);
        chk("empty_rw_count", 32'(bus.o_count), 32'd1);
        for (int i = 0; i < 4; i++) cyc(1, WIDTH'(i + 6), 0);
        chk("five_count", 32'(bus.o_count), 32'd5);
        rst = 1'b1;
        cyc(0, 0, 0);
        rst = 1'b0;
        chk("midrst_count", 32'(bus.o_count), 32'd0);
        chk("midrst_empty", 32'(bus.o_empty_out), 32'd1);
        cyc(1, 4'hE, 0);
        chk("post_rst_data", 32'(bus.o_data_out), 32'hE);
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            cyc(bit'($urandom_range(0, 2) != 0), WIDTH'($urandom), bit'($urandom_range(0, 1)));
        end
        rst = 1'b0;
        for (int i = 0; i < 300; i++)
            cyc(bit'($urandom_range(0, 1)), WIDTH'($urandom), bit'($urandom_range(0, 3) != 0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
